// File: rtl/serial_compare_if.sv
// Handshake bundle for serial_compare: request (start_*, A, B, m),
// result (res_*, g, l) and busy status; master = requester, slave = comparator.
interface serial_compare_if #(
    parameter int N = 8
);
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [1:0]   m;
    logic         res_valid;
    logic         res_ready;
    logic         g;
    logic         l;
    logic         busy;

    modport master (
        output start_valid, A, B, m, res_ready,
        input  start_ready, res_valid, g, l, busy
    );

    modport slave (
        input  start_valid, A, B, m, res_ready,
        output start_ready, res_valid, g, l, busy
    );
endinterface

// File: rtl/serial_compare.sv
// Bit-serial MSB-first magnitude comparator (unsigned/signed, optional swap).
// Ports: clk, rst (async, active-high), bus (serial_compare_if.slave).
// Optional: SERIAL_COMPARE_EARLY_EXIT_EN finishes on the deciding bit.
module serial_compare #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_compare_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          decided;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [1:0]    m_r;
    logic          g_r;
    logic          l_r;
    logic          sr_r;
    logic          rv_r;
    logic          busy_r;

    logic abit;
    logic bbit;
    logic inv;
    logic hit;
    logic new_g;
    logic new_l;
    logic last;
    logic stop;

    always_comb begin
        abit  = 1'b0;
        bbit  = 1'b0;
        inv   = 1'b0;
        hit   = 1'b0;
        new_g = 1'b0;
        new_l = 1'b0;
        last  = 1'b0;
        stop  = 1'b0;
        abit  = m_r[1] ? b_r[idx] : a_r[idx];
        bbit  = m_r[1] ? a_r[idx] : b_r[idx];
        // The sign bit carries negative weight, so its sense flips.
        inv   = m_r[0] && (idx == IW'(N - 1));
        new_g = inv ? (~abit & bbit) : (abit & ~bbit);
        new_l = inv ? (abit & ~bbit) : (~abit & bbit);
        hit   = !decided && (abit ^ bbit);
        last  = (idx == '0);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        stop  = last || hit;
`else
        stop  = last;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            decided <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            m_r     <= '0;
            g_r     <= 1'b0;
            l_r     <= 1'b0;
            sr_r    <= 1'b1;
            rv_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_r     <= bus.A;
                        b_r     <= bus.B;
                        m_r     <= bus.m;
                        idx     <= IW'(N - 1);
                        decided <= 1'b0;
                        g_r     <= 1'b0;
                        l_r     <= 1'b0;
                        sr_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hit) begin
                        g_r     <= new_g;
                        l_r     <= new_l;
                        decided <= 1'b1;
                    end
                    if (stop) begin
                        rv_r  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        rv_r   <= 1'b0;
                        busy_r <= 1'b0;
                        sr_r   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = sr_r;
    assign bus.res_valid   = rv_r;
    assign bus.g           = g_r;
    assign bus.l           = l_r;
    assign bus.busy        = busy_r;
endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_valid  input  1  request to compare the presented operands.
REQ-005 SHALL have port start_ready  output  1  block idle and able to accept a request.
REQ-006 SHALL have port A  input  N  first operand, sampled on accept.
REQ-007 SHALL have port B  input  N  second operand, sampled on accept.
REQ-008 SHALL have port m  input  2  mode, sampled on accept: m[0]=1 signed two's complement, m[1]=1 swap A and B.
REQ-009 SHALL have port res_valid  output  1  g and l hold a valid result.
REQ-010 SHALL have port res_ready  input  1  consumer takes the result.
REQ-011 SHALL have port g  output  1  result: first operand greater.
REQ-012 SHALL have port l  output  1  result: first operand less (g=l=0 means equal).
REQ-013 SHALL have port busy  output  1  high in SHIFT and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE; start_ready=1 only in IDLE, and res_valid=1 only in DONE.
REQ-015 SHALL accept a request on a rising edge in IDLE with start_valid=1: latch A, B and m, set bit index to N-1, clear the internal decided flag and g and l, and enter SHIFT.
REQ-016 SHALL ignore start_valid outside IDLE and SHALL NOT let A, B or m changes after accept affect the result.
REQ-017 SHALL, in SHIFT, examine exactly one bit pair per cycle MSB-first (index N-1 down to 0), using the swapped pair when latched m[1]=1.
REQ-018 SHALL decide on the first differing bit pair when not yet decided: a=1,b=0 gives g=1; a=0,b=1 gives l=1; when latched m[0]=1 and the index is N-1, the sense is inverted.
REQ-019 SHALL ignore every bit pair after the decision; g and l never both 1.
REQ-020 SHALL go from SHIFT to DONE after examining index 0; base latency is accept edge plus N SHIFT cycles, with res_valid high in cycle N+1 after accept.
REQ-021 SHALL hold g, l and res_valid stable in DONE until res_ready=1, then return to IDLE on that edge; start_ready rises the following cycle, with no same-cycle re-accept.
REQ-022 SHALL treat all four m values as valid, with none reserved.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-SHIFT or DONE, enter IDLE asynchronously with start_ready=1, res_valid=0, g=0, l=0, busy=0, bit index=0 and decided flag=0; the in-flight request is discarded.
REQ-024 SHALL, on rst deassertion, accept a request at the first rising edge with start_valid=1.

Configuration
REQ-025 SHALL, when macro SERIAL_COMPARE_EARLY_EXIT_EN is defined, go from SHIFT to DONE on the edge that examines the deciding bit; latency is then N-1-k+1 SHIFT cycles for deciding index k, and equal operands still take N cycles.
REQ-026 SHALL, when SERIAL_COMPARE_EARLY_EXIT_EN is undefined, always spend exactly N SHIFT cycles regardless of the decision point.

Verification
REQ-027 SHALL cover: N=8, m=00, A=0x80, B=0x7F -> g=1, l=0, res_valid 9 cycles after accept, or 2 with early exit.
REQ-028 SHALL cover: m=01, A=0x80 (-128), B=0x7F -> g=0, l=1; and m=01, A=0xFF, B=0xFE -> g=1, l=0.
REQ-029 SHALL cover: m=10, A=0x05, B=0x09 -> g=1, l=0; and m=00, A=B=0x3C -> g=0, l=0 after 8 SHIFT cycles in both configurations.
REQ-030 SHALL cover: res_ready held 0 for 5 cycles in DONE, with A and B toggled and start_valid=1 -> result stable, no new accept, IDLE one cycle after res_ready=1.
REQ-031 SHALL cover: rst pulsed at SHIFT cycle 3 -> next cycle IDLE, g=l=0, res_valid=0; a new request A=0x01, B=0x02 then gives l=1.
